// File: rtl/coms_pkg.sv
// coms_pkg: shared definitions for the motor-side command link.
//   - magic numbers and total lengths of the three master frame types
//   - frame_type_t: which frame the receiver is currently collecting
//   - nextCRC16_D8: one-byte step of CRC16 (x^16+x^15+x^2+1), MSB first
package coms_pkg;

  localparam int MAGIC_LEN      = 4;
  localparam int LEN_STATUS_REQ = 7;
  localparam int LEN_SETPOINT   = 10;
  localparam int LEN_CONTROL    = 26;
  localparam int PAYLOAD_MAX    = LEN_CONTROL - MAGIC_LEN;

  localparam logic [31:0] MAGIC_STATUS_REQ = 32'h1CE1_CEBB;
  localparam logic [31:0] MAGIC_SETPOINT   = 32'hD0D0_D0D0;
  localparam logic [31:0] MAGIC_CONTROL    = 32'hBAAD_A555;

  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    NONE,
    STATUS_REQ,
    SETPOINT,
    CONTROL_MODE
  } frame_type_t;

  // Bit 7 of the byte enters the register first.
  function automatic logic [15:0] nextCRC16_D8(input logic [7:0] data,
                                               input logic [15:0] crc);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
    return c;
  endfunction

endpackage

// File: rtl/coms_crc16_acc.sv
// coms_crc16_acc: byte-serial CRC16 accumulator.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (crc -> FFFF)
//   clear       - restart the running CRC at FFFF
//   enable      - fold data into the running CRC this cycle
//   data        - byte to accumulate
//   crc         - running CRC value
module coms_crc16_acc
  import coms_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      crc <= CRC16_INIT;
    end else if (enable) begin
      crc <= nextCRC16_D8(data, crc);
    end
  end

endmodule

// File: rtl/coms_frame_decoder.sv
// coms_frame_decoder: hunts the received byte stream for status-request,
// setpoint and control-mode frames, checks CRC16 and motor ID, loads the
// decoded control registers and emits one-cycle update strobes.
// Optional build macro: COMS_DECODER_BROADCAST_EN - also accept id FF for
// setpoint and control-mode frames (status requests to FF stay unanswered).
// Ports:
//   clk, reset                         - clock, synchronous active-high reset
//   rx_data, rx_data_ready             - received byte and its valid strobe
//   control_mode, Kp, Ki, Kd           - decoded mode and PID gains
//   PWMLimit, IntegralLimit, deadband  - controller limits (raw)
//   setpoint                           - target setpoint (raw)
//   control_mode_update                - pulse: control-mode frame accepted
//   setpoint_update                    - pulse: setpoint frame accepted
//   status_request                     - pulse: status request for MY_ID
//   crc_error_count, timeout_count,
//   frame_count                        - saturating diagnostics
//
// state     | meaning
// S_HUNT    | shifting bytes through the magic detector
// S_RECEIVE | collecting id/payload/CRC bytes of the latched frame type
// S_CHECK   | one cycle: compare CRC and id, load registers, pulse
module coms_frame_decoder
  import coms_pkg::*;
#(
  parameter logic [7:0] MY_ID               = 8'd0,
  parameter int         BYTE_TIMEOUT_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_data_ready,
  output logic [7:0]         control_mode,
  output logic signed [15:0] Kp,
  output logic signed [15:0] Ki,
  output logic signed [15:0] Kd,
  output logic signed [23:0] PWMLimit,
  output logic signed [23:0] IntegralLimit,
  output logic signed [23:0] deadband,
  output logic signed [23:0] setpoint,
  output logic               control_mode_update,
  output logic               setpoint_update,
  output logic               status_request,
  output logic [15:0]        crc_error_count,
  output logic [15:0]        timeout_count,
  output logic [15:0]        frame_count
);

  localparam int TW = (BYTE_TIMEOUT_CYCLES < 2) ? 1 : $clog2(BYTE_TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] GAP_RELOAD = TW'(BYTE_TIMEOUT_CYCLES);
  localparam logic [4:0]    BUF_DEPTH  = 5'(PAYLOAD_MAX);

  typedef enum logic [1:0] {S_HUNT, S_RECEIVE, S_CHECK} state_t;

  state_t      state, state_nxt;
  logic [31:0] shift_q;
  logic [31:0] shifted;
  frame_type_t ftype, hit_type;
  logic [4:0]  remaining, hit_len;
  logic [4:0]  idx;
  logic [TW-1:0] gap_timer;
  logic [15:0] rx_crc, crc_calc;
  logic [7:0]  pbuf [PAYLOAD_MAX];
  logic [7:0]  frame_id;
  logic        magic_hit, crc_clear, crc_en, timeout_hit, frame_ok, crc_bad, id_ok;

  assign shifted  = {shift_q[23:0], rx_data};
  assign frame_id = pbuf[0];

  coms_crc16_acc u_crc (
    .clk    (clk),
    .reset  (reset),
    .clear  (crc_clear),
    .enable (crc_en),
    .data   (rx_data),
    .crc    (crc_calc)
  );

  always_comb begin
    id_ok = (frame_id == MY_ID);
`ifdef COMS_DECODER_BROADCAST_EN
    if (frame_id == 8'hFF) id_ok = (ftype != STATUS_REQ);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_HUNT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    hit_type    = NONE;
    hit_len     = '0;
    magic_hit   = 1'b0;
    crc_clear   = 1'b0;
    crc_en      = 1'b0;
    timeout_hit = 1'b0;
    frame_ok    = 1'b0;
    crc_bad     = 1'b0;
    case (state)
      S_HUNT: begin
        if (rx_data_ready) begin
          case (shifted)
            MAGIC_STATUS_REQ: begin hit_type = STATUS_REQ;   hit_len = 5'(LEN_STATUS_REQ - MAGIC_LEN); end
            MAGIC_SETPOINT:   begin hit_type = SETPOINT;     hit_len = 5'(LEN_SETPOINT - MAGIC_LEN);   end
            MAGIC_CONTROL:    begin hit_type = CONTROL_MODE; hit_len = 5'(LEN_CONTROL - MAGIC_LEN);    end
            default: ;
          endcase
          if (hit_type != NONE) begin
            magic_hit = 1'b1;
            crc_clear = 1'b1;
            state_nxt = S_RECEIVE;
          end
        end
      end
      S_RECEIVE: begin
        if (rx_data_ready) begin
          // The final two bytes carry the CRC itself.
          crc_en = (remaining > 5'd2);
          if (remaining == 5'd1) state_nxt = S_CHECK;
        end else if (gap_timer == '0) begin
          timeout_hit = 1'b1;
          state_nxt   = S_HUNT;
        end
      end
      S_CHECK: begin
        state_nxt = S_HUNT;
        if (crc_calc != rx_crc) crc_bad  = 1'b1;
        else if (id_ok)         frame_ok = 1'b1;
      end
      default: state_nxt = S_HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == S_RECEIVE && rx_data_ready && idx < BUF_DEPTH) begin
      pbuf[idx] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q             <= '0;
      ftype               <= NONE;
      remaining           <= '0;
      idx                 <= '0;
      gap_timer           <= '0;
      rx_crc              <= '0;
      control_mode        <= '0;
      Kp                  <= '0;
      Ki                  <= '0;
      Kd                  <= '0;
      PWMLimit            <= '0;
      IntegralLimit       <= '0;
      deadband            <= '0;
      setpoint            <= '0;
      control_mode_update <= 1'b0;
      setpoint_update     <= 1'b0;
      status_request      <= 1'b0;
      crc_error_count     <= '0;
      timeout_count       <= '0;
      frame_count         <= '0;
    end else begin
      control_mode_update <= 1'b0;
      setpoint_update     <= 1'b0;
      status_request      <= 1'b0;

      // Payload bytes bypass the magic detector, so a magic inside a payload
      // cannot resynchronise; a byte landing in CHECK is still hunted.
      if (rx_data_ready && state != S_RECEIVE) begin
        shift_q <= magic_hit ? 32'd0 : shifted;
      end

      if (magic_hit) begin
        ftype     <= hit_type;
        remaining <= hit_len;
        idx       <= '0;
        gap_timer <= GAP_RELOAD;
      end

      if (state == S_RECEIVE) begin
        if (rx_data_ready) begin
          remaining <= remaining - 5'd1;
          idx       <= idx + 5'd1;
          rx_crc    <= {rx_crc[7:0], rx_data};
          gap_timer <= GAP_RELOAD;
        end else if (gap_timer != '0) begin
          gap_timer <= gap_timer - 1'b1;
        end
      end

      if (timeout_hit && timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
      if (crc_bad && crc_error_count != 16'hFFFF) crc_error_count <= crc_error_count + 16'd1;

      if (frame_ok) begin
        if (frame_count != 16'hFFFF) frame_count <= frame_count + 16'd1;
        case (ftype)
          CONTROL_MODE: begin
            control_mode        <= pbuf[1];
            Kp                  <= {pbuf[2], pbuf[3]};
            Ki                  <= {pbuf[4], pbuf[5]};
            Kd                  <= {pbuf[6], pbuf[7]};
            PWMLimit            <= {pbuf[8], pbuf[9], pbuf[10]};
            IntegralLimit       <= {pbuf[11], pbuf[12], pbuf[13]};
            deadband            <= {pbuf[14], pbuf[15], pbuf[16]};
            setpoint            <= {pbuf[17], pbuf[18], pbuf[19]};
            control_mode_update <= 1'b1;
          end
          SETPOINT: begin
            setpoint        <= {pbuf[1], pbuf[2], pbuf[3]};
            setpoint_update <= 1'b1;
          end
          STATUS_REQ: status_request <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule
